// File: rtl/run_seq_pkg.sv
// Shared state encoding and default parameters for the run sequencer.
package run_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        FIN,
        PAUSE
    } run_state_t;

    localparam int unsigned DEF_D       = 9;
    localparam int unsigned DEF_C       = 16;
    localparam int unsigned DEF_MAX_CYC = 32'h0000_FFF0;

    localparam logic [8:0] DEF_START0 = 9'd0;
    localparam logic [8:0] DEF_START1 = 9'd128;
    localparam logic [8:0] DEF_START2 = 9'd256;
    localparam logic [8:0] DEF_START3 = 9'd384;

endpackage

// File: rtl/run_cycle_ctr.sv
// Clearable, enabled cycle counter; tc flags the last cycle before the limit is reached.
module run_cycle_ctr
    import run_seq_pkg::*;
#(
    parameter int unsigned C     = DEF_C,
    parameter int unsigned LIMIT = DEF_MAX_CYC
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [C-1:0] cnt,
    output logic         tc
);

    localparam logic [C-1:0] TC_VAL = C'(LIMIT - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + C'(1);
        end
    end

    assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/run_sequencer.sv
// Bounded run controller for the 9-bit core: entry select, PC load, cycle-limited RUN, done handshake.
// Optional breakpoint/pause support is compiled in with RUN_SEQ_BREAKPOINT_EN.
//
// state | meaning
// IDLE  | waiting for req, core stopped
// LOAD  | PC loads the selected entry address
// RUN   | core executing, cycles counted
// DRAIN | one idle cycle so the last write settles
// FIN   | done reported until req is withdrawn
// PAUSE | breakpoint hit, core frozen until resume
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int unsigned   D       = DEF_D,
    parameter int unsigned   C       = DEF_C,
    parameter int unsigned   MAX_CYC = DEF_MAX_CYC,
    parameter logic [D-1:0]  START0  = D'(DEF_START0),
    parameter logic [D-1:0]  START1  = D'(DEF_START1),
    parameter logic [D-1:0]  START2  = D'(DEF_START2),
    parameter logic [D-1:0]  START3  = D'(DEF_START3)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    input  logic [1:0]   prog_sel,
    input  logic         halt_i,
    input  logic [D-1:0] prog_ctr_i,
`ifdef RUN_SEQ_BREAKPOINT_EN
    input  logic         bp_valid,
    input  logic [D-1:0] bp_addr,
    input  logic         resume,
    output logic         paused,
`endif
    output logic         pc_load_o,
    output logic [D-1:0] start_addr_o,
    output logic         core_en_o,
    output logic         busy,
    output logic         done,
    output logic         timeout,
    output logic [C-1:0] cycle_cnt
);

    run_state_t   state;
    run_state_t   state_nxt;
    logic         cnt_clr;
    logic         cnt_en;
    logic         cnt_tc;
    logic         to_set;
    logic         bp_hit;
    logic [D-1:0] sel_addr;

    always_comb begin
        sel_addr = START0;
        case (prog_sel)
            2'd0: sel_addr = START0;
            2'd1: sel_addr = START1;
            2'd2: sel_addr = START2;
            2'd3: sel_addr = START3;
            default: sel_addr = START0;
        endcase
    end

`ifdef RUN_SEQ_BREAKPOINT_EN
    // Suppresses re-triggering on the breakpoint address just resumed from, until the PC moves.
    logic bp_skip;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bp_skip <= 1'b0;
        end else if (state == PAUSE) begin
            bp_skip <= resume;
        end else if ((state != RUN) || (prog_ctr_i != bp_addr)) begin
            bp_skip <= 1'b0;
        end
    end

    assign bp_hit = (state == RUN) && bp_valid && (prog_ctr_i == bp_addr) && !bp_skip;
    assign paused = (state == PAUSE);
`else
    logic unused_pc;

    assign bp_hit    = 1'b0;
    assign unused_pc = ^prog_ctr_i;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        to_set    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = LOAD;
                    cnt_clr   = 1'b1;
                end
            end
            LOAD: begin
                state_nxt = RUN;
            end
            RUN: begin
                if (bp_hit) begin
                    state_nxt = PAUSE;
                end else begin
                    cnt_en = 1'b1;
                    // halt takes priority over the terminal count on the same cycle
                    if (halt_i) begin
                        state_nxt = DRAIN;
                    end else if (cnt_tc) begin
                        state_nxt = DRAIN;
                        to_set    = 1'b1;
                    end
                end
            end
            DRAIN: begin
                state_nxt = FIN;
            end
            FIN: begin
                if (!req) begin
                    state_nxt = IDLE;
                end
            end
`ifdef RUN_SEQ_BREAKPOINT_EN
            PAUSE: begin
                if (resume) begin
                    state_nxt = RUN;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_addr_o <= START0;
            timeout      <= 1'b0;
        end else begin
            if (cnt_clr) begin
                start_addr_o <= sel_addr;
                timeout      <= 1'b0;
            end else if (to_set) begin
                timeout <= 1'b1;
            end
        end
    end

    run_cycle_ctr #(
        .C     (C),
        .LIMIT (MAX_CYC)
    ) u_cycle_ctr (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (cycle_cnt),
        .tc    (cnt_tc)
    );

    assign pc_load_o = (state == LOAD);
    assign core_en_o = (state == RUN) && !bp_hit;
    assign busy      = (state == LOAD) || (state == RUN) || (state == DRAIN) || (state == PAUSE);
    assign done      = (state == FIN);

endmodule

// File: tb/tb_run_sequencer.sv
// Randomized self-checking bench for run_sequencer against a run-level reference model.
module tb_run_sequencer;

    localparam int D    = 9;
    localparam int C    = 16;
    localparam int MAXC = 20;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         req = 1'b0;
    logic [1:0]   prog_sel = 2'd0;
    logic         halt_i = 1'b0;
    logic [D-1:0] prog_ctr_i = '0;
`ifdef RUN_SEQ_BREAKPOINT_EN
    logic         bp_valid = 1'b0;
    logic [D-1:0] bp_addr = '0;
    logic         resume = 1'b0;
    logic         paused;
`endif
    logic         pc_load_o;
    logic [D-1:0] start_addr_o;
    logic         core_en_o;
    logic         busy;
    logic         done;
    logic         timeout;
    logic [C-1:0] cycle_cnt;

    run_sequencer #(
        .D       (D),
        .C       (C),
        .MAX_CYC (MAXC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .prog_sel     (prog_sel),
        .halt_i       (halt_i),
        .prog_ctr_i   (prog_ctr_i),
`ifdef RUN_SEQ_BREAKPOINT_EN
        .bp_valid     (bp_valid),
        .bp_addr      (bp_addr),
        .resume       (resume),
        .paused       (paused),
`endif
        .pc_load_o    (pc_load_o),
        .start_addr_o (start_addr_o),
        .core_en_o    (core_en_o),
        .busy         (busy),
        .done         (done),
        .timeout      (timeout),
        .cycle_cnt    (cycle_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int unsigned start_tab[4] = '{0, 128, 256, 384};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: a run lasts min(halt_at, MAXC) RUN cycles; timeout only if halt never came in time.
    task automatic run_one(input int sel, input int halt_at, input int drop_at, input int hold_fin);
        int n;
        bit exp_to;
        bit dropped;
        n       = (halt_at <= MAXC) ? halt_at : MAXC;
        exp_to  = (halt_at > MAXC);
        dropped = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_en", core_en_o, 0);
        prog_sel = 2'(sel);
        req      = 1'b1;
        @(negedge clk);
        check("load_pc", pc_load_o, 1);
        check("load_addr", start_addr_o, start_tab[sel]);
        check("load_en", core_en_o, 0);
        check("load_busy", busy, 1);
        check("load_cnt", cycle_cnt, 0);
        prog_sel = 2'($urandom_range(0, 3));
        for (int r = 1; r <= n; r++) begin
            @(negedge clk);
            check("run_en", core_en_o, 1);
            check("run_busy", busy, 1);
            check("run_pcload", pc_load_o, 0);
            check("run_cnt", cycle_cnt, r - 1);
            check("run_to", timeout, 0);
            prog_ctr_i = D'(start_tab[sel] + r);
            halt_i     = (r == halt_at);
            if (r == drop_at) begin
                req     = 1'b0;
                dropped = 1'b1;
            end
        end
        @(negedge clk);
        halt_i = 1'b0;
        check("drain_en", core_en_o, 0);
        check("drain_busy", busy, 1);
        check("drain_done", done, 0);
        @(negedge clk);
        check("fin_done", done, 1);
        check("fin_busy", busy, 0);
        check("fin_en", core_en_o, 0);
        check("fin_cnt", cycle_cnt, n);
        check("fin_to", timeout, exp_to);
        check("fin_addr", start_addr_o, start_tab[sel]);
        if (!dropped) begin
            for (int h = 0; h < hold_fin; h++) begin
                halt_i = 1'($urandom_range(0, 1));
                @(negedge clk);
                check("hold_done", done, 1);
                check("hold_pcload", pc_load_o, 0);
                check("hold_cnt", cycle_cnt, n);
                check("hold_to", timeout, exp_to);
            end
            halt_i = 1'b0;
            req    = 1'b0;
        end
        @(negedge clk);
        check("ret_done", done, 0);
        check("ret_busy", busy, 0);
        check("ret_cnt", cycle_cnt, n);
    endtask

    task automatic reset_mid_run();
        @(negedge clk);
        prog_sel = 2'd3;
        req      = 1'b1;
        @(negedge clk);
        check("rst_load_pc", pc_load_o, 1);
        for (int r = 1; r <= 5; r++) begin
            @(negedge clk);
            check("rst_run_en", core_en_o, 1);
        end
        reset = 1'b0;
        req   = 1'b0;
        #1;
        check("rst_async_en", core_en_o, 0);
        check("rst_async_busy", busy, 0);
        check("rst_async_pc", pc_load_o, 0);
        check("rst_async_done", done, 0);
        check("rst_async_to", timeout, 0);
        check("rst_async_cnt", cycle_cnt, 0);
        check("rst_async_addr", start_addr_o, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rst_idle_busy", busy, 0);
            check("rst_idle_en", core_en_o, 0);
            check("rst_idle_pc", pc_load_o, 0);
            check("rst_idle_done", done, 0);
        end
    endtask

    initial begin
        int sel;
        int halt_at;
        int n;
        int drop_at;
        repeat (2) @(negedge clk);
        check("reset_pc", pc_load_o, 0);
        check("reset_addr", start_addr_o, 0);
        check("reset_en", core_en_o, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_to", timeout, 0);
        check("reset_cnt", cycle_cnt, 0);
        reset = 1'b1;

        run_one(2, 10, 0, 2);
        run_one(1, 1000, 0, 0);
        run_one(0, MAXC, 0, 1);
        run_one(3, MAXC + 1, 0, 0);
        run_one(3, 7, 4, 0);
        run_one(1, 1, 0, 3);
        reset_mid_run();
        run_one(2, 3, 0, 0);

        for (int i = 0; i < 30; i++) begin
            sel     = int'($urandom_range(0, 3));
            halt_at = int'($urandom_range(1, MAXC + 5));
            n       = (halt_at <= MAXC) ? halt_at : MAXC;
            drop_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, n)) : 0;
            run_one(sel, halt_at, drop_at, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
